clk_gate_ctrl: RTL and testbench

Multi-requester clock-gate sequencer for a gated clock branch: an integrated clock gate followed by the clkinv/clkbuf tree driving one clock domain. It merges requests from NREQ clients and FORCE into one registered gate enable EN. It waits a fixed wake-up interval for the tree to settle before acknowledging clients. After the last request drops, it holds the clock on for an idle hysteresis interval before gating it off. It sits in the always-on domain, clocked by the ungated root clock.

---
 rtl/clk_gate_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clk_gate_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
//
// Clock-gate sequencer for one gated clock branch. It merges NREQ client
// requests and a force-on input into a single registered gate enable. The
// enable comes up first. Clients are acknowledged only after WAKE_CYC cycles,
// so the clock tree has time to settle. After the last request goes away, the
// clock stays on for IDLE_CYC cycles of hysteresis before it is gated off.
// The block lives in the always-on domain and runs on the ungated root clock.
//
// Parameters
//   NREQ      number of requesters (>= 1)
//   WAKE_CYC  cycles EN is high before any ACK may assert (>= 1)
//   IDLE_CYC  cycles EN stays high after the last request drops (>= 1)
//   CW        counter width, 2**CW > max(WAKE_CYC, IDLE_CYC) - 1
//
// Ports
//   clk_i    ungated root clock, rising edge
//   rst_i    asynchronous active-high reset
//   req_i    per-client level request
//   force_i  force-on; behaves like a request that never gets an ACK
//   en_o     registered enable to the integrated clock gate
//   ack_o    registered per-client grant; the clock is running while high
//   busy_o   registered, high whenever state_o != OFF
//   state_o  registered FSM state: OFF=0, WAKE=1, ON=2, HOLD=3
//
// States
//   OFF  | clock gated, no grants
//   WAKE | gate enabled, waiting for the tree to settle
//   ON   | clock running, grants follow requests with one cycle of lag
//   HOLD | no requests; clock kept running for the idle hysteresis

module clk_gate_ctrl #(
  parameter int NREQ     = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 8,
  parameter int CW       = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            force_i,
  output logic            en_o,
  output logic [NREQ-1:0] ack_o,
  output logic            busy_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYC - 1);
  localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic any_req;
  logic cnt_zero;

  // FORCE counts as a request for sequencing, but it is never granted.
  assign any_req  = (|req_i) | force_i;
  assign cnt_zero = (cnt_q == '0);

  // State register. Reset clears everything at once, so EN drops straight
  // away. Glitch-free gating is left to the latch inside the clock gate.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  // Next state and counter. The counter counts down and does not wrap. It
  // only moves while it is nonzero in WAKE or HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (any_req) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LD;
        end
      end
      ST_WAKE: begin
        // A request that drops during the wake interval does not cut it
        // short. The interval always runs to the end, then the FSM goes
        // to ON or HOLD.
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (any_req) begin
          state_d = ST_ON;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = IDLE_LD;
        end
      end
      ST_ON: begin
        if (!any_req) begin
          state_d = ST_HOLD;
          cnt_d   = IDLE_LD;
        end
      end
      ST_HOLD: begin
        // The clock never stopped, so a new request goes straight to ON
        // without another wake interval.
        if (any_req) begin
          state_d = ST_ON;
        end else if (cnt_zero) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs are derived from the next state. This keeps
  // "ACK != 0 implies ON and EN" true by construction. Grants copy the
  // sampled requests only while the FSM is in ON.
  always_comb begin
    en_d   = (state_d != ST_OFF);
    busy_d = (state_d != ST_OFF);
    ack_d  = (state_d == ST_ON) ? req_i : '0;
  end

  assign en_o    = en_q;
  assign busy_o  = busy_q;
  assign ack_o   = ack_q;
  assign state_o = state_q;

`ifndef SYNTHESIS
  a_ack_implies_on : assert property (@(posedge clk_i) disable iff (rst_i)
    (ack_q != '0) |-> (state_q == ST_ON && en_q));
  a_off_when_gated : assert property (@(posedge clk_i) disable iff (rst_i)
    !en_q |-> (state_q == ST_OFF));
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;

  localparam int NREQ = 4;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic            frc;
  logic            en;
  logic [NREQ-1:0] ack;
  logic            busy;
  logic [1:0]      state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic            en;
    logic [NREQ-1:0] ack;
    logic [1:0]      st;
    string           tag;
  } exp_t;

  exp_t exp_q[$];

  clk_gate_ctrl #(.NREQ(4), .WAKE_CYC(2), .IDLE_CYC(8), .CW(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .force_i(frc),
    .en_o   (en),
    .ack_o  (ack),
    .busy_o (busy),
    .state_o(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_en, input logic [NREQ-1:0] e_ack,
                           input logic [1:0] e_st);
    check({tag, ".en"},    {7'd0, en},   {7'd0, e_en});
    check({tag, ".ack"},   {4'd0, ack},  {4'd0, e_ack});
    check({tag, ".state"}, {6'd0, state}, {6'd0, e_st});
    check({tag, ".busy"},  {7'd0, busy}, {7'd0, (e_st != 2'd0)});
  endtask

  // Monitor: after every active edge, pop the expected response and compare.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_all(e.tag, e.en, e.ack, e.st);
    end
  end

  // Drive one cycle of inputs. Queue what the outputs must be after the next edge.
  task automatic step(input logic [NREQ-1:0] r, input logic f, input logic e_en,
                      input logic [NREQ-1:0] e_ack, input logic [1:0] e_st, input string tag);
    exp_t e;
    @(negedge clk);
    req = r;
    frc = f;
    e.en = e_en; e.ack = e_ack; e.st = e_st; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // From OFF with a request: two WAKE cycles, then ON with the grant.
  task automatic wake(input logic [NREQ-1:0] r, input logic f, input string tag);
    step(r, f, 1'b1, 4'b0000, 2'd1, {tag, "_w0"});
    step(r, f, 1'b1, 4'b0000, 2'd1, {tag, "_w1"});
    step(r, f, 1'b1, r,       2'd2, {tag, "_on"});
  endtask

  // All requests low: 8 HOLD results, then OFF.
  task automatic drop_to_off(input string tag);
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b0, 1'b1, 4'b0000, 2'd3, $sformatf("%s_h%0d", tag, i));
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, {tag, "_off"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    frc = 1'b0;
    #2;
    check_all("rst_async", 1'b0, 4'b0000, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    check_all("rst_hold", 1'b0, 4'b0000, 2'd0);

    // Release reset with all requests high.
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{1'b1, 4'b0000, 2'd1, "rel_w0"});
    step(4'b1111, 1'b0, 1'b1, 4'b0000, 2'd1, "rel_w1");
    step(4'b1111, 1'b0, 1'b1, 4'b1111, 2'd2, "rel_on");
    step(4'b1111, 1'b0, 1'b1, 4'b1111, 2'd2, "rel_on2");
    drop_to_off("rel");

    // Single request for 10 cycles.
    wake(4'b0001, 1'b0, "single");
    for (int i = 0; i < 7; i++) step(4'b0001, 1'b0, 1'b1, 4'b0001, 2'd2, $sformatf("single_on%0d", i));
    drop_to_off("single");

    // Re-request 4 cycles into HOLD.
    wake(4'b0010, 1'b0, "reacq");
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b1, 4'b0000, 2'd3, $sformatf("reacq_h%0d", i));
    step(4'b0010, 1'b0, 1'b1, 4'b0010, 2'd2, "reacq_on");
    // One bit falls while another rises in the same cycle: stays ON.
    step(4'b0101, 1'b0, 1'b1, 4'b0101, 2'd2, "swap1");
    step(4'b1000, 1'b0, 1'b1, 4'b1000, 2'd2, "swap2");
    drop_to_off("reacq");

    // Request drops during WAKE.
    step(4'b0100, 1'b0, 1'b1, 4'b0000, 2'd1, "wdrop_w0");
    step(4'b0000, 1'b0, 1'b1, 4'b0000, 2'd1, "wdrop_w1");
    drop_to_off("wdrop");

    // FORCE only, for 20 cycles.
    wake(4'b0000, 1'b1, "force");
    for (int i = 0; i < 17; i++) step(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd2, $sformatf("force_on%0d", i));
    // A request under FORCE is granted. Dropping it keeps ON with ACK=0.
    step(4'b0001, 1'b1, 1'b1, 4'b0001, 2'd2, "force_req");
    step(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd2, "force_req_drop");
    drop_to_off("force");

    // Reset asserted mid-ON.
    wake(4'b0011, 1'b0, "mid");
    step(4'b0011, 1'b0, 1'b1, 4'b0011, 2'd2, "mid_on2");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all("mid_rst_async", 1'b0, 4'b0000, 2'd0);
    @(posedge clk);
    #1;
    check_all("mid_rst_hold", 1'b0, 4'b0000, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{1'b1, 4'b0000, 2'd1, "mid_rel_w0"});
    step(4'b0011, 1'b0, 1'b1, 4'b0000, 2'd1, "mid_rel_w1");
    step(4'b0011, 1'b0, 1'b1, 4'b0011, 2'd2, "mid_rel_on");
    drop_to_off("mid");

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
